// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the five-stage pipeline: tracks EX/MEM/WB occupancy and derives
// stall, flush and EX forwarding selects, including a multi-cycle load wait.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_WAIT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      ex_branch_taken,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      stall_m,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      ex_valid,
  output logic                      mem_valid,
  output logic                      wb_valid,
  output logic                      mem_busy
);
  localparam int W = REG_ADDR_WIDTH;

  if (LOAD_WAIT < 0 || LOAD_WAIT > 15) begin : g_bad_load_wait
    $error("pipe_hazard_ctrl: LOAD_WAIT must be in 0..15");
  end

  typedef struct packed {
    logic         valid;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         uses_rs1;
    logic         uses_rs2;
    logic [W-1:0] rd;
    logic         reg_write;
    logic         mem_read;
  } ex_rec_t;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] rd;
    logic         reg_write;
    logic         mem_read;
  } mem_rec_t;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] rd;
    logic         reg_write;
  } wb_rec_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  ex_rec_t  ex_q;
  mem_rec_t mem_q;
  wb_rec_t  wb_q;
  state_t   state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic busy, wait_done, branch, load_use, mem_fwd, wb_fwd;

  assign busy      = (state_q == S_WAIT);
  assign wait_done = busy && (cnt_q == 4'd1);
  assign branch    = ex_q.valid && ex_branch_taken;
  // Loads in MEM have no data yet, so only ALU results forward from there.
  assign mem_fwd   = mem_q.valid && mem_q.reg_write && !mem_q.mem_read && (mem_q.rd != '0);
  assign wb_fwd    = wb_q.valid && wb_q.reg_write && (wb_q.rd != '0);
  assign load_use  = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0) && id_valid &&
                     ((id_uses_rs1 && id_rs1 == ex_q.rd) || (id_uses_rs2 && id_rs2 == ex_q.rd));

  // The wait subsumes every other hazard; a taken branch overrides load-use (ID is wrong-path).
  assign flush_d   = branch && !busy;
  assign flush_e   = (branch || load_use) && !busy;
  assign stall_f   = busy || (load_use && !branch);
  assign stall_d   = stall_f;
  assign stall_e   = busy;
  assign stall_m   = busy;
  assign mem_busy  = busy;
  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_q.valid && ex_q.uses_rs1 && ex_q.rs1 != '0) begin
      if (mem_fwd && mem_q.rd == ex_q.rs1)     fwd_a = 2'b10;
      else if (wb_fwd && wb_q.rd == ex_q.rs1)  fwd_a = 2'b01;
    end
    if (ex_q.valid && ex_q.uses_rs2 && ex_q.rs2 != '0) begin
      if (mem_fwd && mem_q.rd == ex_q.rs2)     fwd_b = 2'b10;
      else if (wb_fwd && wb_q.rd == ex_q.rs2)  fwd_b = 2'b01;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (LOAD_WAIT > 0 && ex_q.valid && ex_q.mem_read) begin
        state_d = S_WAIT;
        cnt_d   = 4'(LOAD_WAIT);
      end
      S_WAIT: if (cnt_q == 4'd1) begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (busy) begin
        // The finished load retires on the last wait edge; younger stages stay put.
        if (wait_done) begin
          wb_q  <= '{mem_q.valid, mem_q.rd, mem_q.reg_write};
          mem_q <= '0;
        end else begin
          wb_q  <= '0;
        end
      end else begin
        wb_q  <= '{mem_q.valid, mem_q.rd, mem_q.reg_write};
        mem_q <= '{ex_q.valid, ex_q.rd, ex_q.reg_write, ex_q.mem_read};
        if (flush_e || !id_valid) ex_q <= '0;
        else ex_q <= '{1'b1, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
                       id_rd, id_reg_write, id_mem_read};
      end
    end
  end
endmodule
